// File: rtl/disp_scan.sv
// disp_scan: multiplexed scan driver for a common-anode 7-segment bank.
// Captures N_DIG nibbles on load, walks the digits once per CLK_DIV cycles
// and drives one registered nibble (zi) plus an active-low one-hot anode (an).
// Optional build macro DISP_SCAN_BLANK_EN enables leading-zero blanking.
module disp_scan #(
    parameter int CLK_DIV = 50000,
    parameter int N_DIG   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_DIG-1:0] value,
    input  logic               load,
    output logic [3:0]         zi,
    output logic [N_DIG-1:0]   an
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

    // Packed so that nibble i lines up with value[4i+3:4i].
    logic [N_DIG-1:0][3:0] shadow_q, shadow_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            zi_q, zi_d;
    logic [N_DIG-1:0]      an_q, an_d;
    logic [N_DIG-1:0]      blank;

`ifdef DISP_SCAN_BLANK_EN
    // A digit above 0 goes dark while it and every higher nibble are zero.
    always_comb begin
        logic nz;
        nz    = 1'b0;
        blank = '0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            nz       = nz | (|shadow_q[i]);
            blank[i] = ~nz;
        end
    end
`else
    assign blank = '0;
`endif

    // Capture, prescaler and digit index next-state; load and slot advance are independent.
    always_comb begin
        shadow_d = load ? value : shadow_q;
        pre_d    = pre_q + PRE_W'(1);
        idx_d    = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Output next-state is taken from current state, so outputs trail state by one cycle.
    always_comb begin
        zi_d = shadow_q[idx_q];
        an_d = blank[idx_q] ? '1 : ~(N_DIG'(1) << idx_q);
    end

    // State and output registers; reset darkens the display and restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            zi_q     <= 4'h0;
            an_q     <= '1;
        end else begin
            shadow_q <= shadow_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            zi_q     <= zi_d;
            an_q     <= an_d;
        end
    end

    assign zi = zi_q;
    assign an = an_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: a 4-digit/4-cycle instance and a 2-digit/1-cycle instance.
module tb_disp_scan;

`ifdef DISP_SCAN_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst1 = 1'b1, load1 = 1'b0;
    logic [15:0] value1 = '0;
    logic [3:0]  zi1, an1;
    logic        rst2 = 1'b1, load2 = 1'b0;
    logic [7:0]  value2 = '0;
    logic [3:0]  zi2;
    logic [1:0]  an2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       b;
        logic [3:0] an;
        logic [3:0] zi;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    disp_scan #(.CLK_DIV(4), .N_DIG(4)) u_a (
        .clk(clk), .rst(rst1), .value(value1), .load(load1), .zi(zi1), .an(an1)
    );

    disp_scan #(.CLK_DIV(1), .N_DIG(2)) u_b (
        .clk(clk), .rst(rst2), .value(value2), .load(load2), .zi(zi2), .an(an2)
    );

    task automatic push(input string tag, input logic b, input logic [3:0] ean, input logic [3:0] ezi);
        exp_t e;
        e.tag = tag; e.b = b; e.an = ean; e.zi = ezi;
        sbq.push_back(e);
    endtask

    // Advance one edge, then pop the oldest expectation and compare away from the edge.
    task automatic tick_check();
        exp_t       e;
        logic [3:0] oan, ozi;
        @(posedge clk);
        #1;
        e   = sbq.pop_front();
        oan = e.b ? {2'b11, an2} : an1;
        ozi = e.b ? zi2 : zi1;
        checks++;
        assert (oan === e.an) else begin
            errors++;
            $error("FAIL %s an: got %b expected %b", e.tag, oan, e.an);
        end
        checks++;
        assert (ozi === e.zi) else begin
            errors++;
            $error("FAIL %s zi: got %h expected %h", e.tag, ozi, e.zi);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ean, input logic [3:0] ezi);
        push(tag, 1'b0, ean, ezi);
        tick_check();
    endtask

    task automatic step2(input string tag, input logic [1:0] ean, input logic [3:0] ezi);
        push(tag, 1'b1, {2'b11, ean}, ezi);
        tick_check();
    endtask

    function automatic logic [3:0] an_for(input int s, input logic [3:0] m);
        logic [3:0] one;
        one = 4'b0001;
        return (BL && m[s]) ? 4'hF : ~(one << s);
    endfunction

    // Reset (possibly mid-scan), load v on the release edge, check a full frame plus the wrap slot.
    task automatic scan_from_reset(input string tag, input logic [15:0] v, input logic [3:0] m);
        rst1 = 1'b1;
        step({tag, "_rst"}, 4'hF, 4'h0);
        rst1 = 1'b0; load1 = 1'b1; value1 = v;
        step({tag, "_rel"}, 4'hE, 4'h0);
        load1 = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++)
                if (!(s == 0 && c == 0))
                    step({tag, "_scan"}, an_for(s, m), v[4*s +: 4]);
        for (int c = 0; c < 4; c++)
            step({tag, "_wrap"}, 4'hE, v[3:0]);
    endtask

    initial begin
        // Reset held three edges on the 4x4 instance.
        for (int k = 0; k < 3; k++) step("reset", 4'hF, 4'h0);

        scan_from_reset("s1A2F", 16'h1A2F, 4'b0000);

        // Mid-slot load while digit 2 of 1234 is displayed.
        rst1 = 1'b1;
        step("ms_rst", 4'hF, 4'h0);
        rst1 = 1'b0; load1 = 1'b1; value1 = 16'h1234;
        step("ms_rel", 4'hE, 4'h0);
        load1 = 1'b0;
        for (int c = 0; c < 3; c++) step("ms_d0", 4'hE, 4'h4);
        for (int c = 0; c < 4; c++) step("ms_d1", 4'hD, 4'h3);
        step("ms_d2", 4'hB, 4'h2);
        load1 = 1'b1; value1 = 16'h5678;
        step("ms_ld", 4'hB, 4'h2);
        load1 = 1'b0;
        step("ms_new", 4'hB, 4'h6);
        step("ms_new", 4'hB, 4'h6);
        for (int c = 0; c < 4; c++) step("ms_d3", 4'h7, 4'h5);
        for (int c = 0; c < 4; c++) step("ms_d0b", 4'hE, 4'h8);
        for (int c = 0; c < 4; c++) step("ms_d1b", 4'hD, 4'h7);
        step("ms_d2b", 4'hB, 4'h6);

        // Next reset lands mid-digit-2; each run restarts with a full digit-0 slot.
        scan_from_reset("s0007", 16'h0007, 4'b1110);
        scan_from_reset("s0000", 16'h0000, 4'b1110);
        scan_from_reset("s0100", 16'h0100, 4'b1000);

        // CLK_DIV=1, N_DIG=2 instance: digit changes every cycle.
        step2("b_reset", 2'b11, 4'h0);
        rst2 = 1'b0; load2 = 1'b1; value2 = 8'h3C;
        step2("b_rel", 2'b10, 4'h0);
        load2 = 1'b0;
        for (int k = 0; k < 6; k++)
            if (k % 2 == 0) step2("b_alt", 2'b01, 4'h3);
            else            step2("b_alt", 2'b10, 4'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
